// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences filter/ifmap loading into three PEs, starts compute and waits for results.
module pe_array_ctrl #(
    parameter int FILT_WORDS = 4,
    parameter int IF_WORDS   = 8,
    parameter int OUT_WORDS  = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       filt_full,
    input  logic [2:0] if_full,
    input  logic [2:0] pe_done,
    input  logic       res_wr,
    output logic       sel_addr_SRAM,
    output logic       filt_cnt_en,
    output logic       if_cnt_en,
    output logic       filter_wen,
    output logic [2:0] ifmap_wen,
    output logic       start_PE,
    output logic       busy,
    output logic       job_done
);
    typedef enum logic [2:0] {IDLE, LOAD_FILT, LOAD_IF, RUN, DRAIN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] res_q, res_d;
    logic [1:0]           idx_q, idx_d;
    logic [2:0]           mask_q, mask_d;
    logic                 first_q, first_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        first_d = first_q;
        // results are counted from the first RUN cycle and saturate at OUT_WORDS
        res_d   = ((state_q == RUN || state_q == DRAIN) && res_wr && res_q != CNT_WIDTH'(OUT_WORDS))
                  ? res_q + CNT_WIDTH'(1) : res_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_FILT;
                cnt_d   = '0;
                idx_d   = '0;
                mask_d  = '0;
                res_d   = '0;
                first_d = 1'b0;
            end
            LOAD_FILT: if (filter_wen) begin
                if (cnt_q == CNT_WIDTH'(FILT_WORDS - 1)) begin
                    state_d = LOAD_IF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            LOAD_IF: if (if_cnt_en) begin
                if (cnt_q == CNT_WIDTH'(IF_WORDS - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 2'd2) begin
                        state_d = RUN;
                        first_d = 1'b1;
                    end else idx_d = idx_q + 2'd1;
                end else cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            RUN: begin
                first_d = 1'b0;
                mask_d  = first_q ? mask_q : mask_q | pe_done;
                if (mask_d == 3'b111) state_d = DRAIN;
            end
            DRAIN: if (res_d == CNT_WIDTH'(OUT_WORDS)) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_addr_SRAM = state_q == LOAD_FILT;
        filter_wen    = state_q == LOAD_FILT && !filt_full;
        ifmap_wen     = (state_q == LOAD_IF && !if_full[idx_q]) ? 3'b001 << idx_q : 3'b000;
        filt_cnt_en   = filter_wen;
        if_cnt_en     = |ifmap_wen;
        start_PE      = state_q == RUN && first_q;
        busy          = state_q != IDLE;
        job_done      = state_q == FINISH;
    end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: directed scenarios for pe_array_ctrl with default parameters.
module tb_pe_array_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, filt_full, res_wr;
    logic [2:0] if_full, pe_done;
    logic       sel_addr_SRAM, filt_cnt_en, if_cnt_en, filter_wen, start_PE, busy, job_done;
    logic [2:0] ifmap_wen;
    int         checks = 0;
    int         errors = 0;

    pe_array_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .filt_full(filt_full), .if_full(if_full),
        .pe_done(pe_done), .res_wr(res_wr), .sel_addr_SRAM(sel_addr_SRAM),
        .filt_cnt_en(filt_cnt_en), .if_cnt_en(if_cnt_en), .filter_wen(filter_wen),
        .ifmap_wen(ifmap_wen), .start_PE(start_PE), .busy(busy), .job_done(job_done)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; filt_full = 1'b0; if_full = 3'b000; pe_done = 3'b000; res_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        do_reset();
        #1;
        outs = {sel_addr_SRAM, filt_cnt_en, if_cnt_en, filter_wen, ifmap_wen, start_PE, busy, job_done};
        checks++;
        if (outs !== 10'd0) begin errors++; $display("FAIL reset_outs got %b exp 0", outs); end
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_over_start busy got %b exp 0", busy); end
    endtask

    task automatic test_nominal();
        logic [2:0] e_if;
        do_reset();
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            start   = c == 0;
            pe_done = c >= 31 ? 3'b111 : 3'b000;
            res_wr  = c >= 32 && c <= 37;
            #1;
            e_if = (c >= 5 && c <= 12) ? 3'b001 : (c >= 13 && c <= 20) ? 3'b010 :
                   (c >= 21 && c <= 28) ? 3'b100 : 3'b000;
            checks += 7;
            if (filter_wen !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL nom_filter_wen c=%0d got %b", c, filter_wen); end
            if (filt_cnt_en !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL nom_filt_cnt_en c=%0d got %b", c, filt_cnt_en); end
            if (sel_addr_SRAM !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL nom_sel c=%0d got %b", c, sel_addr_SRAM); end
            if (ifmap_wen !== e_if || if_cnt_en !== |e_if) begin errors++; $display("FAIL nom_ifmap c=%0d got %b/%b exp %b", c, ifmap_wen, if_cnt_en, e_if); end
            if (start_PE !== (c == 29)) begin errors++; $display("FAIL nom_start_PE c=%0d got %b", c, start_PE); end
            if (job_done !== (c == 38)) begin errors++; $display("FAIL nom_job_done c=%0d got %b", c, job_done); end
            if (busy !== (c >= 1 && c <= 38)) begin errors++; $display("FAIL nom_busy c=%0d got %b", c, busy); end
        end
        res_wr = 1'b0; pe_done = 3'b000;
    endtask

    task automatic test_filt_stall();
        int nw = 0;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            start     = c == 0;
            filt_full = c >= 2 && c <= 4;
            #1;
            if (filter_wen) nw++;
            checks += 2;
            if (filter_wen !== (c == 1 || (c >= 5 && c <= 7))) begin errors++; $display("FAIL stall_filter_wen c=%0d got %b", c, filter_wen); end
            if (filt_cnt_en !== filter_wen) begin errors++; $display("FAIL stall_cnt_en c=%0d got %b wen %b", c, filt_cnt_en, filter_wen); end
        end
        checks++;
        if (nw != 4) begin errors++; $display("FAIL stall_writes got %0d exp 4", nw); end
        checks++;
        if (ifmap_wen !== 3'b001) begin errors++; $display("FAIL stall_ifmap_start got %b exp 001", ifmap_wen); end
        filt_full = 1'b0;
    endtask

    task automatic test_pe_pulses();
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            start   = c == 0;
            pe_done = c == 31 ? 3'b100 : c == 33 ? 3'b001 : c == 35 ? 3'b010 : 3'b000;
            res_wr  = c >= 30 && c <= 35;
            #1;
            if (c >= 29) begin
                checks += 2;
                if (job_done !== (c == 37)) begin errors++; $display("FAIL pulse_job_done c=%0d got %b", c, job_done); end
                if (busy !== (c <= 37)) begin errors++; $display("FAIL pulse_busy c=%0d got %b", c, busy); end
            end
        end
        pe_done = 3'b000; res_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [9:0] outs;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            @(negedge clk);
            start = c == 0 || c == 17;
            rst   = c == 15;
            #1;
            if (c == 14) begin
                checks++;
                if (ifmap_wen !== 3'b010) begin errors++; $display("FAIL mid_idx1 got %b exp 010", ifmap_wen); end
            end
            if (c == 16) begin
                outs = {sel_addr_SRAM, filt_cnt_en, if_cnt_en, filter_wen, ifmap_wen, start_PE, busy, job_done};
                checks++;
                if (outs !== 10'd0) begin errors++; $display("FAIL mid_reset_outs got %b exp 0", outs); end
            end
            if (c >= 18) begin
                checks += 2;
                if (filter_wen !== (c <= 21)) begin errors++; $display("FAIL mid_reload_filt c=%0d got %b", c, filter_wen); end
                if (ifmap_wen !== (c == 22 ? 3'b001 : 3'b000)) begin errors++; $display("FAIL mid_reload_if c=%0d got %b", c, ifmap_wen); end
            end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_start_ignored();
        int nd = 0;
        int ns = 0;
        do_reset();
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            start   = c == 0 || c == 2 || c == 29 || c == 30;
            pe_done = c >= 31 ? 3'b111 : 3'b000;
            res_wr  = c >= 32 && c <= 37;
            #1;
            if (job_done) nd++;
            if (start_PE) ns++;
            if (c >= 39) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy c=%0d got %b exp 0", c, busy); end
            end
        end
        checks += 2;
        if (nd != 1) begin errors++; $display("FAIL ign_job_done count got %0d exp 1", nd); end
        if (ns != 1) begin errors++; $display("FAIL ign_start_PE count got %0d exp 1", ns); end
        pe_done = 3'b000; res_wr = 1'b0;
    endtask

    task automatic test_res_split();
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            start   = c == 0;
            pe_done = c >= 31 ? 3'b111 : 3'b000;
            res_wr  = c == 3 || c == 10 || c == 29 || c == 30 || c == 31 || c == 33 || c == 35 || c == 37;
            #1;
            if (c >= 29) begin
                checks++;
                if (job_done !== (c == 38)) begin errors++; $display("FAIL split_job_done c=%0d got %b", c, job_done); end
            end
        end
        pe_done = 3'b000; res_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; filt_full = 1'b0; if_full = 3'b000; pe_done = 3'b000; res_wr = 1'b0;
        test_reset();
        test_nominal();
        test_filt_stall();
        test_pe_pulses();
        test_reset_mid();
        test_start_ignored();
        test_res_split();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
